// File: rtl/pla_bus_ctrl.sv
// C64 bus controller: two-phase 1 MHz enables, PLA bank decode, one-hot chip selects and BA-gated CPU RDY.
// Optional Ultimax cartridge mapping is compiled in with `define PLA_ULTIMAX_EN.
module pla_bus_ctrl #(
    parameter int CLK_DIV         = 8,
    parameter int BA_WRITE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_ph1_en,
    output logic        o_ph2_en,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_we,
    input  logic [2:0]  i_port,
    input  logic        i_game_n,
    input  logic        i_exrom_n,
    input  logic        i_ba,
    output logic        o_rdy,
    output logic [3:0]  o_src,
    output logic [13:0] o_cs,
    output logic        o_ram_we
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = (BA_WRITE_CYCLES < 1) ? 1 : $clog2(BA_WRITE_CYCLES + 1);
    localparam logic [CW-1:0] PH1_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PH2_LAST  = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BA_RELOAD = BW'(BA_WRITE_CYCLES);

    localparam logic [3:0] SRC_RAM    = 4'd0;
    localparam logic [3:0] SRC_BASIC  = 4'd1;
    localparam logic [3:0] SRC_KERNAL = 4'd2;
    localparam logic [3:0] SRC_CHAR   = 4'd3;
    localparam logic [3:0] SRC_VIC    = 4'd4;
    localparam logic [3:0] SRC_SID    = 4'd5;
    localparam logic [3:0] SRC_COLOR  = 4'd6;
    localparam logic [3:0] SRC_CIA1   = 4'd7;
    localparam logic [3:0] SRC_CIA2   = 4'd8;
    localparam logic [3:0] SRC_IO1    = 4'd9;
    localparam logic [3:0] SRC_IO2    = 4'd10;
    localparam logic [3:0] SRC_ROML   = 4'd11;
    localparam logic [3:0] SRC_ROMH   = 4'd12;
`ifdef PLA_ULTIMAX_EN
    localparam logic [3:0] SRC_OPEN   = 4'd13;
`endif

    logic [CW-1:0] phase;
    logic          started;
    logic          charen, hiram, loram, game_n, exrom_n;
    logic [BW-1:0] ba_cnt;
    logic          game_eff_n, no_cart, cart16;
    logic [3:0]    io_src, src;

    // started keeps phase 2 quiet until the first phase 1 has been issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            started  <= 1'b0;
            o_ph1_en <= 1'b0;
            o_ph2_en <= 1'b0;
        end else begin
            phase    <= (phase == PH1_LAST) ? '0 : phase + CW'(1);
            o_ph1_en <= (phase == PH1_LAST);
            o_ph2_en <= started && (phase == PH2_LAST);
            if (phase == PH1_LAST) started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {charen, hiram, loram} <= 3'b111;
            game_n                 <= 1'b1;
            exrom_n                <= 1'b1;
        end else if (o_ph1_en) begin
            {charen, hiram, loram} <= i_port;
            game_n                 <= i_game_n;
            exrom_n                <= i_exrom_n;
        end
    end

    // RDY handshake: o_rdy is only ever high in the o_ph1_en cycle; a high o_rdy
    // means the CPU access presented in that cycle completes. With BA low, writes
    // are granted until ba_cnt runs out; any read stalls until BA returns.
    assign o_rdy = o_ph1_en & (i_ba | ((ba_cnt != '0) & i_cpu_we));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ba_cnt <= BA_RELOAD;
        end else if (o_ph1_en) begin
            if (i_ba)       ba_cnt <= BA_RELOAD;
            else if (o_rdy) ba_cnt <= ba_cnt - BW'(1);
        end
    end

`ifdef PLA_ULTIMAX_EN
    assign game_eff_n = game_n;
`else
    // Without Ultimax support, GAME low with EXROM high behaves as no cartridge.
    assign game_eff_n = game_n | exrom_n;
`endif
    assign no_cart = game_eff_n & exrom_n;
    assign cart16  = ~game_eff_n & ~exrom_n;

    always_comb begin
        io_src = SRC_IO2;
        case (i_cpu_addr[11:8])
            4'h0, 4'h1, 4'h2, 4'h3: io_src = SRC_VIC;
            4'h4, 4'h5, 4'h6, 4'h7: io_src = SRC_SID;
            4'h8, 4'h9, 4'hA, 4'hB: io_src = SRC_COLOR;
            4'hC:                   io_src = SRC_CIA1;
            4'hD:                   io_src = SRC_CIA2;
            4'hE:                   io_src = SRC_IO1;
            default:                io_src = SRC_IO2;
        endcase
    end

    always_comb begin
        src = SRC_RAM;
`ifdef PLA_ULTIMAX_EN
        if (!game_n && exrom_n) begin
            if (i_cpu_addr < 16'h1000)      src = SRC_RAM;
            else if (i_cpu_addr < 16'h8000) src = SRC_OPEN;
            else if (i_cpu_addr < 16'hA000) src = SRC_ROML;
            else if (i_cpu_addr < 16'hD000) src = SRC_OPEN;
            else if (i_cpu_addr < 16'hE000) src = io_src;
            else                            src = SRC_ROMH;
        end else
`endif
        if (i_cpu_addr >= 16'hE000) begin
            if (hiram) src = SRC_KERNAL;
        end else if (i_cpu_addr >= 16'hD000) begin
            if (loram | hiram) src = charen ? io_src : SRC_CHAR;
        end else if (i_cpu_addr >= 16'hA000) begin
            if (loram & hiram & no_cart) src = SRC_BASIC;
            else if (cart16 & hiram)     src = SRC_ROMH;
        end else if (i_cpu_addr >= 16'h8000) begin
            if (!exrom_n && loram && hiram) src = SRC_ROML;
        end
    end

    assign o_src    = src;
    assign o_cs     = 14'd1 << src;
    // ROM windows are write-through to the RAM underneath them.
    assign o_ram_we = i_cpu_we & o_rdy & (src <= SRC_CHAR);

endmodule

// File: tb/tb_pla_bus_ctrl.sv
// Self-checking bench for pla_bus_ctrl: directed test-plan checks plus randomized traffic against a behavioural model.
// Honours `define PLA_ULTIMAX_EN the same way the design does.
module tb_pla_bus_ctrl;
    localparam int CLK_DIV = 8;
    localparam int BAW     = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_ph1_en, o_ph2_en, o_rdy, o_ram_we;
    logic [15:0] i_cpu_addr = 16'h0000;
    logic        i_cpu_we = 1'b0;
    logic [2:0]  i_port = 3'b111;
    logic        i_game_n = 1'b1;
    logic        i_exrom_n = 1'b1;
    logic        i_ba = 1'b1;
    logic [3:0]  o_src;
    logic [13:0] o_cs;

    int checks = 0;
    int fails  = 0;

    // model state
    int       m_n = 0;
    bit [2:0] m_port = 3'b111;
    bit       m_game_n = 1'b1;
    bit       m_exrom_n = 1'b1;
    int       m_ba_left = BAW;

    always #5 clk = ~clk;

    pla_bus_ctrl #(.CLK_DIV(CLK_DIV), .BA_WRITE_CYCLES(BAW)) dut (
        .clk(clk), .rst_n(rst_n), .o_ph1_en(o_ph1_en), .o_ph2_en(o_ph2_en),
        .i_cpu_addr(i_cpu_addr), .i_cpu_we(i_cpu_we), .i_port(i_port),
        .i_game_n(i_game_n), .i_exrom_n(i_exrom_n), .i_ba(i_ba), .o_rdy(o_rdy),
        .o_src(o_src), .o_cs(o_cs), .o_ram_we(o_ram_we)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int io_model(input int a);
        if (a < 'hD400) return 4;
        if (a < 'hD800) return 5;
        if (a < 'hDC00) return 6;
        if (a < 'hDD00) return 7;
        if (a < 'hDE00) return 8;
        if (a < 'hDF00) return 9;
        return 10;
    endfunction

    function automatic int src_model(input int a, input bit [2:0] port, input bit gn, input bit en);
        bit charen, hiram, loram, no_cart, cart16;
        charen = port[2];
        hiram  = port[1];
        loram  = port[0];
`ifdef PLA_ULTIMAX_EN
        if (!gn && en) begin
            if (a < 'h1000) return 0;
            if (a < 'h8000) return 13;
            if (a < 'hA000) return 11;
            if (a < 'hD000) return 13;
            if (a < 'hE000) return io_model(a);
            return 12;
        end
`else
        if (!gn && en) gn = 1'b1;
`endif
        no_cart = gn && en;
        cart16  = !gn && !en;
        if (a >= 'hE000) return hiram ? 2 : 0;
        if (a >= 'hD000) return (loram || hiram) ? (charen ? io_model(a) : 3) : 0;
        if (a >= 'hA000) begin
            if (loram && hiram && no_cart) return 1;
            if (cart16 && hiram) return 12;
            return 0;
        end
        if (a >= 'h8000) return (!en && loram && hiram) ? 11 : 0;
        return 0;
    endfunction

    // Per-cycle comparison against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        bit exp_ph1, exp_ph2, exp_rdy, exp_we;
        int exp_src;
        if (!rst_n) begin
            m_n = 0; m_port = 3'b111; m_game_n = 1'b1; m_exrom_n = 1'b1; m_ba_left = BAW;
        end
        exp_ph1 = rst_n && m_n > 0 && (m_n % CLK_DIV) == 0;
        exp_ph2 = rst_n && m_n >= CLK_DIV + CLK_DIV / 2 && (m_n % CLK_DIV) == CLK_DIV / 2;
        exp_src = src_model(int'(i_cpu_addr), m_port, m_game_n, m_exrom_n);
        exp_rdy = exp_ph1 && (i_ba || (m_ba_left > 0 && i_cpu_we));
        exp_we  = exp_rdy && i_cpu_we && exp_src <= 3;
        check("ph1", int'(o_ph1_en), int'(exp_ph1));
        check("ph2", int'(o_ph2_en), int'(exp_ph2));
        check("src", int'(o_src), exp_src);
        check("cs", int'(o_cs), 1 << exp_src);
        check("rdy", int'(o_rdy), int'(exp_rdy));
        check("ram_we", int'(o_ram_we), int'(exp_we));
        if (rst_n) begin
            if (exp_ph1) begin
                m_port = i_port; m_game_n = i_game_n; m_exrom_n = i_exrom_n;
                if (i_ba) m_ba_left = BAW;
                else if (exp_rdy) m_ba_left--;
            end
            m_n++;
        end
    end

    // Returns just after the edge that raised o_ph1_en.
    task automatic wait_ph1();
        for (int i = 0; i < 3 * CLK_DIV; i++) begin
            @(posedge clk); #1;
            if (o_ph1_en) return;
        end
        check("ph1_timeout", 0, 1);
    endtask

    task automatic set_check_src(input logic [15:0] a, input int exp, input string name);
        i_cpu_addr = a;
        #1 check(name, int'(o_src), exp);
    endtask

    task automatic apply_mode(input logic [2:0] port, input logic gn, input logic en);
        wait_ph1();
        i_port = port; i_game_n = gn; i_exrom_n = en;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] got1[$];
        logic [31:0] got2[$];
        logic [15:0] a_list[5];
        int          a_exp[5];
        logic [2:0]  seq_port[4];
        int          seq_a[4];
        int          seq_d[4];

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 3 * CLK_DIV; k++) begin
            @(posedge clk); #1;
            if (o_ph1_en) got1.push_back(k);
            if (o_ph2_en) got2.push_back(k);
        end
        exp_q = '{8, 16, 24};
        check("ph1_count", got1.size(), exp_q.size());
        foreach (exp_q[i]) check("ph1_edge", (i < got1.size()) ? int'(got1[i]) : -1, int'(exp_q[i]));
        exp_q = '{12, 20};
        check("ph2_count", got2.size(), exp_q.size());
        foreach (exp_q[i]) check("ph2_edge", (i < got2.size()) ? int'(got2[i]) : -1, int'(exp_q[i]));

        // default map, port 111, no cartridge
        a_list = '{16'hA123, 16'hE000, 16'hD020, 16'hDD00, 16'hDF00};
        a_exp  = '{1, 2, 4, 8, 10};
        @(posedge clk); #1;
        foreach (a_list[i]) set_check_src(a_list[i], a_exp[i], "dec111");
        wait_ph1();
        i_cpu_addr = 16'hE000; i_cpu_we = 1'b1;
        #1 check("we_kernal", int'(o_ram_we), 1);
        @(posedge clk); #1 i_cpu_we = 1'b0;

        // port walk: old mapping holds for the sampling cycle, new mapping after it
        seq_port = '{3'b111, 3'b110, 3'b101, 3'b000};
        seq_a    = '{1, 0, 0, 0};
        seq_d    = '{4, 4, 4, 0};
        for (int i = 1; i < 4; i++) begin
            wait_ph1();
            i_port = seq_port[i];
            set_check_src(16'hA000, seq_a[i-1], "port_old_a");
            set_check_src(16'hD000, seq_d[i-1], "port_old_d");
            @(posedge clk); #1;
            set_check_src(16'hA000, seq_a[i], "port_new_a");
            set_check_src(16'hD000, seq_d[i], "port_new_d");
        end
        apply_mode(3'b111, 1'b1, 1'b1);

        // BA stall: four writes pending
        i_cpu_addr = 16'h1000;
        wait_ph1();
        @(posedge clk); #1 i_ba = 1'b0; i_cpu_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ph1();
            check("ba_write_rdy", int'(o_rdy), (i < 3) ? 1 : 0);
            check("ba_write_we", int'(o_ram_we), (i < 3) ? 1 : 0);
        end
        @(posedge clk); #1 i_ba = 1'b1;
        wait_ph1();
        check("ba_release", int'(o_rdy), 1);
        // read first: immediate stall that lasts until BA returns
        @(posedge clk); #1 i_ba = 1'b0; i_cpu_we = 1'b0;
        wait_ph1();
        check("ba_read_stall", int'(o_rdy), 0);
        wait_ph1();
        check("ba_read_stall2", int'(o_rdy), 0);
        @(posedge clk); #1 i_ba = 1'b1;
        wait_ph1();
        check("ba_read_release", int'(o_rdy), 1);

        // 16K cartridge
        apply_mode(3'b111, 1'b0, 1'b0);
        set_check_src(16'h8000, 11, "cart16_roml");
        set_check_src(16'hA000, 12, "cart16_romh");
        set_check_src(16'hE000, 2, "cart16_kernal");

        // GAME low, EXROM high
        apply_mode(3'b000, 1'b0, 1'b1);
`ifdef PLA_ULTIMAX_EN
        set_check_src(16'h4000, 13, "umax_open");
        set_check_src(16'hD000, 4, "umax_vic");
        set_check_src(16'hE000, 12, "umax_romh");
`else
        set_check_src(16'h4000, 0, "game_only_4000");
        set_check_src(16'hD000, 0, "game_only_d000");
        set_check_src(16'hE000, 0, "game_only_e000");
`endif
        apply_mode(3'b111, 1'b1, 1'b1);

        // reset asserted in the middle of a phase-1 pulse
        wait_ph1();
        #1 rst_n = 1'b0;
        #1 check("midrst_ph1", int'(o_ph1_en), 0);
        check("midrst_ph2", int'(o_ph2_en), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // randomized traffic; the per-cycle compare does the checking
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            i_cpu_addr = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) i_cpu_addr[15:12] = 4'hD;
            i_cpu_we  = 1'($urandom_range(0, 1));
            i_port    = 3'($urandom_range(0, 7));
            i_game_n  = 1'($urandom_range(0, 1));
            i_exrom_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) i_ba = ~i_ba;
        end

        repeat (2) @(posedge clk);
        #1 $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
